// File: rtl/exibe_sequencia.sv
// Sequence presenter: walks the sequence memory from address 0 to a latched last
// index, lighting each entry on the LEDs for T_ACESO cycles then blanking for T_APAGADO.
module exibe_sequencia #(
  parameter int T_ACESO   = 1000,
  parameter int T_APAGADO = 100,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              abortar,
  input  logic [ADDR_W-1:0] ultima_pos,
  output logic [ADDR_W-1:0] mem_endereco,
  input  logic [DATA_W-1:0] mem_dado,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  // state    | meaning
  // INICIAL  | idle, waiting for iniciar
  // ENDERECA | address presented to the sequence memory
  // CAPTURA  | memory data valid, captured into the LED register
  // ACESO    | entry lit for T_ACESO cycles
  // APAGADO  | LEDs blank for T_APAGADO cycles, then next entry or FIM
  // FIM      | one-cycle pronto pulse
  localparam logic [2:0] INICIAL  = 3'd0;
  localparam logic [2:0] ENDERECA = 3'd1;
  localparam logic [2:0] CAPTURA  = 3'd2;
  localparam logic [2:0] ACESO    = 3'd3;
  localparam logic [2:0] APAGADO  = 3'd4;
  localparam logic [2:0] FIM      = 3'd5;

  localparam int T_MAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
  localparam int TMR_W = $clog2(T_MAX + 1);
  localparam logic [TMR_W-1:0] FIM_ACESO   = TMR_W'(T_ACESO - 1);
  localparam logic [TMR_W-1:0] FIM_APAGADO = TMR_W'(T_APAGADO - 1);

  logic [2:0]        estado;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] ult;
  logic [DATA_W-1:0] leds_reg;
  logic [TMR_W-1:0]  timer;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= INICIAL;
      addr     <= '0;
      ult      <= '0;
      leds_reg <= '0;
      timer    <= '0;
    end else if (abortar && (estado != INICIAL)) begin
      estado <= INICIAL;
      addr   <= '0;
      timer  <= '0;
    end else begin
      case (estado)
        INICIAL: begin
          if (iniciar) begin
            ult    <= ultima_pos;
            addr   <= '0;
            timer  <= '0;
            estado <= ENDERECA;
          end
        end
        ENDERECA: begin
          timer  <= '0;
          estado <= CAPTURA;
        end
        CAPTURA: begin
          leds_reg <= mem_dado;
          timer    <= '0;
          estado   <= ACESO;
        end
        ACESO: begin
          if (timer == FIM_ACESO) begin
            timer  <= '0;
            estado <= APAGADO;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        APAGADO: begin
          if (timer == FIM_APAGADO) begin
            timer <= '0;
            // addr stops at ult, so it can never wrap
            if (addr == ult) begin
              estado <= FIM;
            end else begin
              addr   <= addr + 1'b1;
              estado <= ENDERECA;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FIM: begin
          timer  <= '0;
          estado <= INICIAL;
        end
        default: begin
          timer  <= '0;
          estado <= INICIAL;
        end
      endcase
    end
  end

  assign mem_endereco = addr;
  assign leds         = (estado == ACESO) ? leds_reg : '0;
  assign ocupado      = (estado != INICIAL);
  assign pronto       = (estado == FIM);
  assign db_estado    = {1'b0, estado};

endmodule

// File: tb/tb_exibe_sequencia.sv
// Bench for exibe_sequencia: short-timer instance checked by a per-entry scoreboard,
// plus a default-parameter instance for the full 16-entry run length.
module tb_exibe_sequencia;

  localparam int TA = 4;
  localparam int TP = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, iniciar, abortar, ocupado, pronto;
  logic [3:0] ultima_pos, mem_endereco, mem_dado, leds, db_estado;

  logic       iniciar_d, abortar_d, ocupado_d, pronto_d;
  logic [3:0] ultima_pos_d, mem_endereco_d, mem_dado_d, leds_d, db_estado_d;

  exibe_sequencia #(.T_ACESO(TA), .T_APAGADO(TP), .ADDR_W(4), .DATA_W(4)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar),
    .ultima_pos(ultima_pos), .mem_endereco(mem_endereco), .mem_dado(mem_dado),
    .leds(leds), .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
  );

  exibe_sequencia dut_d (
    .clock(clock), .reset(reset), .iniciar(iniciar_d), .abortar(abortar_d),
    .ultima_pos(ultima_pos_d), .mem_endereco(mem_endereco_d), .mem_dado(mem_dado_d),
    .leds(leds_d), .ocupado(ocupado_d), .pronto(pronto_d), .db_estado(db_estado_d)
  );

  // sequence memory with one cycle of read latency
  logic [3:0] mem [16];
  always @(posedge clock) begin
    mem_dado   <= mem[mem_endereco];
    mem_dado_d <= mem[mem_endereco_d];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] val;
    logic [3:0] addr;
  } ent_t;

  ent_t       exp_q[$];
  ent_t       exp_e;
  int         exp_pronto = 0;
  bit         skip_ep = 0;
  bit         have_prev = 0;
  int         lit_len = 0;
  int         blank_len = 0;
  logic [3:0] lit_val, lit_addr;

  // monitor: turns the LED waveform into lit episodes and matches them against exp_q
  always @(negedge clock) begin
    if (!$isunknown(leds) && (leds != 4'h0)) begin
      if (lit_len == 0) begin
        if (have_prev) chk("entry_gap", 32'(blank_len), 32'(TP + 2));
        lit_val  = leds;
        lit_addr = mem_endereco;
      end else begin
        chk("lit_stable", 32'(leds), 32'(lit_val));
        chk("addr_stable", 32'(mem_endereco), 32'(lit_addr));
      end
      lit_len++;
    end else begin
      if (lit_len != 0) begin
        if (skip_ep) begin
          skip_ep = 0;
        end else begin
          chk("entry_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_e = exp_q.pop_front();
            chk("entry_val", 32'(lit_val), 32'(exp_e.val));
            chk("entry_addr", 32'(lit_addr), 32'(exp_e.addr));
            chk("entry_len", 32'(lit_len), 32'(TA));
          end
        end
        have_prev = 1;
        blank_len = 0;
        lit_len   = 0;
      end
      blank_len++;
    end
    if (pronto === 1'b1) begin
      chk("pronto_expected", 32'(exp_pronto != 0), 32'd1);
      if (have_prev) chk("tail_gap", 32'(blank_len), 32'(TP + 1));
      if (exp_pronto > 0) exp_pronto--;
    end
    if (ocupado === 1'b0) have_prev = 0;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_run(input int ult);
    for (int i = 0; i <= ult; i++) begin
      ent_t e;
      e.val  = mem[i];
      e.addr = 4'(i);
      exp_q.push_back(e);
    end
    exp_pronto++;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (((ocupado !== 1'b0) || (exp_pronto != 0)) && (k < budget)) begin
      step(1);
      k++;
    end
    chk("run_finished", 32'(ocupado), 32'd0);
    chk("pronto_seen", 32'(exp_pronto), 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_estado"}, 32'(db_estado), 32'd0);
    chk({tag, "_leds"}, 32'(leds), 32'd0);
    chk({tag, "_addr"}, 32'(mem_endereco), 32'd0);
    chk({tag, "_ocupado"}, 32'(ocupado), 32'd0);
    chk({tag, "_pronto"}, 32'(pronto), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int first_lit, n_lit, pronto_at, k, c;
    bit wrapped;
    logic [3:0] prev_addr;

    for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));
    reset = 1; iniciar = 0; abortar = 0; ultima_pos = 0;
    iniciar_d = 0; abortar_d = 0; ultima_pos_d = 0;
    step(2);
    reset = 0;
    step(10);
    chk_idle("reset");

    // single entry, cycle-exact timing
    ultima_pos = 0; iniciar = 1; push_run(0);
    first_lit = -1; n_lit = 0; pronto_at = -1;
    for (int cy = 1; cy <= 12; cy++) begin
      step(1);
      if (cy == 1) begin
        iniciar = 0;
        chk("st_endereca", 32'(db_estado), 32'd1);
      end
      if (cy == 2) chk("st_captura", 32'(db_estado), 32'd2);
      if (leds != 4'h0) begin
        if (first_lit < 0) first_lit = cy;
        n_lit++;
      end
      if (pronto === 1'b1) pronto_at = cy;
    end
    chk("latency", 32'(first_lit), 32'd3);
    chk("lit_cycles", 32'(n_lit), 32'(TA));
    chk("run_cycles", 32'(pronto_at + 1), 32'(1 * (2 + TA + TP) + 2));
    chk("idle_after", 32'(ocupado), 32'd0);

    // four entries
    ultima_pos = 3; iniciar = 1; push_run(3);
    step(1); iniciar = 0;
    wait_idle(200);
    step(20);

    // all sixteen entries
    ultima_pos = 15; iniciar = 1; push_run(15);
    step(1); iniciar = 0;
    wait_idle(400);
    chk("ult15_last_addr", 32'(mem_endereco), 32'd15);
    step(10);

    // iniciar held high; ultima_pos changed mid-run
    ultima_pos = 1; iniciar = 1; push_run(1);
    step(1);
    ultima_pos = 0;
    k = 0;
    while ((pronto !== 1'b1) && (k < 100)) begin step(1); k++; end
    chk("held_pronto1", 32'(pronto), 32'd1);
    push_run(0);
    step(2);
    iniciar = 0;
    wait_idle(100);
    step(15);

    // abort during the 2nd lit entry
    ultima_pos = 3; iniciar = 1; push_run(3);
    step(1); iniciar = 0;
    k = 0;
    while ((leds !== mem[1]) && (k < 100)) begin step(1); k++; end
    chk("reach_2nd_entry", 32'(leds), 32'(mem[1]));
    step(1);
    abortar = 1; skip_ep = 1; exp_q.delete(); exp_pronto = 0;
    step(1);
    abortar = 0;
    chk_idle("abort");
    step(20);

    // iniciar and abortar together in INICIAL: start wins
    ultima_pos = 0; iniciar = 1; abortar = 1; push_run(0);
    step(1);
    iniciar = 0; abortar = 0;
    chk("start_with_abort", 32'(db_estado), 32'd1);
    wait_idle(50);
    step(5);

    // reset in the middle of APAGADO
    ultima_pos = 2; iniciar = 1; push_run(2);
    step(1); iniciar = 0;
    k = 0;
    while ((db_estado !== 4'd4) && (k < 100)) begin step(1); k++; end
    step(1);
    chk("reach_apagado", 32'(db_estado), 32'd4);
    reset = 1; exp_q.delete(); exp_pronto = 0;
    step(1);
    reset = 0;
    chk_idle("mid_reset");
    step(20);

    // default parameters, full sixteen-entry run
    ultima_pos_d = 15; iniciar_d = 1;
    step(1);
    iniciar_d = 0;
    c = 1; wrapped = 0; prev_addr = mem_endereco_d;
    while ((pronto_d !== 1'b1) && (c < 20000)) begin
      step(1);
      c++;
      if (mem_endereco_d < prev_addr) wrapped = 1;
      prev_addr = mem_endereco_d;
    end
    chk("def_run_len", 32'(c + 1), 32'd17634);
    chk("def_no_wrap", 32'(wrapped), 32'd0);
    chk("def_last_addr", 32'(mem_endereco_d), 32'd15);
    step(2);
    chk("def_idle", 32'(ocupado_d), 32'd0);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
